branch_predictor_bht: RTL and testbench



---
 rtl/branch_predictor_bht_pkg.sv | 19 +
 rtl/branch_predictor_bht_if.sv | 28 ++
 rtl/branch_predictor_bht_sat_counter.sv | 24 ++
 rtl/branch_predictor_bht.sv | 97 +++++++++
 tb/tb_branch_predictor_bht.sv | 102 ++++++++++
 5 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the branch history table: next-PC select encoding and table entry layout.
package bp_pkg;

  localparam logic [1:0] MUXPC_SEQ      = 2'd0;
  localparam logic [1:0] MUXPC_PRED     = 2'd1;
  localparam logic [1:0] MUXPC_RECOV_NT = 2'd2;
  localparam logic [1:0] MUXPC_RECOV_T  = 2'd3;

  // Fields are sized for the widest supported PC; narrower configurations zero-extend and the unused flops are constant.
  localparam int PC_W_MAX = 64;

  // Each entry's prediction counter lives in its own sat_counter instance alongside this record.
  typedef struct packed {
    logic                valid;
    logic [PC_W_MAX-1:0] tag;
    logic [PC_W_MAX-1:0] target;
  } bht_entry_t;

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-lookup and decode-resolve signals between the pipeline and the predictor.
interface bp_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            branch_eq;
    logic            equal;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-1:0] id_target;
    logic            id_hit;
    logic            id_pred;
    logic            flush;
    logic [1:0]      muxpc;
    logic [15:0]     mispredict_cnt;

    modport master (
        output if_pc, branch_eq, equal, id_pc, id_target, id_hit, id_pred,
        input  pred_hit, pred_taken, pred_target, flush, muxpc, mispredict_cnt
    );

    modport slave (
        input  if_pc, branch_eq, equal, id_pc, id_target, id_hit, id_pred,
        output pred_hit, pred_taken, pred_target, flush, muxpc, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_bht_sat_counter.sv
// Saturating up/down counter with parallel load; load wins over inc, inc wins over dec.
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [CTR_BITS-1:0] load_val,
    output logic [CTR_BITS-1:0] value
);
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            if (value != '1) value <= value + 1'b1;
        end else if (dec) begin
            if (value != '0) value <= value - 1'b1;
        end
    end
endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table: combinational fetch lookup, decode-stage resolve,
// misprediction recovery select and a saturating mispredict counter.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int PC_W     = 32
) (
    input logic clk,
    input logic rst,
    bp_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - 1'b1;

    bht_entry_t          tbl [ENTRIES];
    logic [CTR_BITS-1:0] ctr [ENTRIES];
    logic [15:0]         mp_cnt;

    logic [IDX_W-1:0]    if_idx, id_idx;
    logic [PC_W_MAX-1:0] if_tag, id_tag, id_target_ext;
    logic                lk_hit, lk_taken, id_match, mispredict, do_update, do_alloc;

    assign if_idx        = bus.if_pc[IDX_W+1:2];
    assign if_tag        = PC_W_MAX'(bus.if_pc[PC_W-1:IDX_W+2]);
    assign id_idx        = bus.id_pc[IDX_W+1:2];
    assign id_tag        = PC_W_MAX'(bus.id_pc[PC_W-1:IDX_W+2]);
    assign id_target_ext = PC_W_MAX'(bus.id_target);

    assign lk_hit   = tbl[if_idx].valid && (tbl[if_idx].tag == if_tag);
    assign lk_taken = lk_hit && ctr[if_idx][CTR_BITS-1];
    assign id_match = tbl[id_idx].valid && (tbl[id_idx].tag == id_tag);

    // A taken branch predicted taken still mispredicts unless the live entry holds the right target.
    assign mispredict = bus.branch_eq &&
                        ((bus.id_pred != bus.equal) ||
                         (bus.id_pred && bus.equal &&
                          (!id_match || (tbl[id_idx].target != id_target_ext))));

    assign do_update = bus.branch_eq && !rst && bus.id_hit && id_match;
    assign do_alloc  = bus.branch_eq && !rst && !do_update;

    always_comb begin
        bus.pred_hit    = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        bus.flush       = 1'b0;
        bus.muxpc       = MUXPC_SEQ;
        if (!rst) begin
            bus.pred_hit    = lk_hit;
            bus.pred_taken  = lk_taken;
            bus.pred_target = lk_hit ? tbl[if_idx].target[PC_W-1:0] : '0;
            if (mispredict) begin
                bus.flush = 1'b1;
                bus.muxpc = bus.equal ? MUXPC_RECOV_T : MUXPC_RECOV_NT;
            end else if (lk_taken) begin
                bus.muxpc = MUXPC_PRED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
        end else if (do_alloc) begin
            tbl[id_idx] <= '{valid: 1'b1, tag: id_tag, target: id_target_ext};
        end else if (do_update && bus.equal) begin
            tbl[id_idx].target <= id_target_ext;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = (id_idx == IDX_W'(g));
        sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .inc      (do_update && sel && bus.equal),
            .dec      (do_update && sel && !bus.equal),
            .load     (do_alloc && sel),
            .load_val (bus.equal ? CTR_WEAK_T : CTR_WEAK_NT),
            .value    (ctr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mp_cnt <= '0;
        end else if (mispredict && (mp_cnt != 16'hFFFF)) begin
            mp_cnt <= mp_cnt + 16'd1;
        end
    end

    assign bus.mispredict_cnt = mp_cnt;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (ENTRIES=16, CTR_BITS=2, PC_W=32) with an expected-result queue.
module tb_branch_predictor_bht;
    localparam int W = 53;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];

    bp_if #(.PC_W(32)) bus ();

    branch_predictor_bht #(.ENTRIES(16), .CTR_BITS(2), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_resolve(input logic beq, input logic eq, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic hit, input logic pred);
        bus.branch_eq = beq;
        bus.equal     = eq;
        bus.id_pc     = pc;
        bus.id_target = tgt;
        bus.id_hit    = hit;
        bus.id_pred   = pred;
    endtask

    // Inputs are already driven just after a falling edge; outputs are sampled 1ns later.
    task automatic step(input string tag, input logic hit, input logic taken, input logic [31:0] tgt,
                        input logic fl, input logic [1:0] mux, input logic [15:0] cnt);
        logic [W-1:0] obs;
        logic [W-1:0] exp_v;
        exp_q.push_back({hit, taken, tgt, fl, mux, cnt});
        #1;
        obs = {bus.pred_hit, bus.pred_taken, bus.pred_target, bus.flush, bus.muxpc, bus.mispredict_cnt};
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed={hit,taken,target,flush,muxpc,cnt}=%h expected=%h", tag, obs, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.if_pc = 32'h0;
        set_resolve(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        step("rst_outputs", 0, 0, 32'h0, 0, 2'd0, 16'd0);
        rst = 1'b0;

        bus.if_pc = 32'h40;
        step("reset_lookup", 0, 0, 32'h0, 0, 2'd0, 16'd0);

        set_resolve(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        step("alloc_same_cycle_miss", 0, 0, 32'h0, 1, 2'd3, 16'd0);
        set_resolve(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("alloc_then_hit", 1, 1, 32'h80, 0, 2'd1, 16'd1);

        set_resolve(1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 1'b1);
        step("nt_mispredict_1", 1, 1, 32'h80, 1, 2'd2, 16'd1);
        step("nt_mispredict_2", 1, 0, 32'h80, 1, 2'd2, 16'd2);
        set_resolve(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("after_two_nt", 1, 0, 32'h80, 0, 2'd0, 16'd3);

        bus.if_pc = 32'h100;
        set_resolve(1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 1'b0);
        step("correct_nt_sat_low", 0, 0, 32'h0, 0, 2'd0, 16'd3);

        bus.if_pc = 32'h40;
        set_resolve(1'b1, 1'b1, 32'h40, 32'h90, 1'b1, 1'b0);
        step("t_mispredict_from_0", 1, 0, 32'h80, 1, 2'd3, 16'd3);
        step("t_mispredict_from_1", 1, 0, 32'h90, 1, 2'd3, 16'd4);
        set_resolve(1'b1, 1'b1, 32'h40, 32'h90, 1'b1, 1'b1);
        step("t_correct", 1, 1, 32'h90, 0, 2'd1, 16'd5);
        set_resolve(1'b1, 1'b1, 32'h40, 32'hA0, 1'b1, 1'b1);
        step("target_mismatch", 1, 1, 32'h90, 1, 2'd3, 16'd5);

        set_resolve(1'b1, 1'b0, 32'h440, 32'h500, 1'b0, 1'b0);
        step("alias_alloc", 1, 1, 32'hA0, 0, 2'd1, 16'd6);
        set_resolve(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("alias_old_miss", 0, 0, 32'h0, 0, 2'd0, 16'd6);
        bus.if_pc = 32'h440;
        step("alias_new_hit", 1, 0, 32'h500, 0, 2'd0, 16'd6);

        rst = 1'b1;
        set_resolve(1'b1, 1'b1, 32'h440, 32'h600, 1'b1, 1'b0);
        step("rst_during_mispredict", 0, 0, 32'h0, 0, 2'd0, 16'd6);
        rst = 1'b0;
        set_resolve(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("post_rst_440_miss", 0, 0, 32'h0, 0, 2'd0, 16'd0);
        bus.if_pc = 32'h40;
        step("post_rst_40_miss", 0, 0, 32'h0, 0, 2'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
